halfword_narrower: RTL and testbench

HALFWORD_NARROWER -- requirements
Module: halfword_narrower

---
 rtl/halfword_narrower.sv | 126 ++++++++++++
 tb/tb_halfword_narrower.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/halfword_narrower.sv
// Purpose: narrows 32-bit words into 16-bit parcels, optionally dropping a zero upper half.
// Latency: first parcel is valid the cycle after the word is accepted.
// Backpressure: out_ready low freezes the parcel; in_ready is only raised when the last parcel leaves.
module halfword_narrower #(
    parameter int COMPRESS_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_half,
    output logic        out_last,
    output logic        out_zext,
    output logic [7:0]  zext_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_hold;
    logic [7:0]  r_zext_cnt;

    logic        w_compress;
    logic        w_out_xfer;
    logic        w_in_xfer;

    // A word may be sent as a single zero-extended parcel only when its upper half is zero.
    assign w_compress = (COMPRESS_EN != 0) && (r_hold[31:16] == 16'h0000);

    // Parcel outputs, handshakes and next state, all decoded from the current state.
    always_comb begin
        out_valid   = 1'b0;
        out_half    = 16'h0000;
        out_last    = 1'b0;
        out_zext    = 1'b0;
        w_state_nxt = r_state;

        case (r_state)
            SEND_LO: begin
                out_valid = 1'b1;
                out_half  = r_hold[15:0];
                out_last  = w_compress;
                out_zext  = w_compress;
            end
            SEND_HI: begin
                out_valid = 1'b1;
                out_half  = r_hold[31:16];
                out_last  = 1'b1;
                out_zext  = 1'b0;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase

        w_out_xfer = out_valid && out_ready;
        // Accepting alongside the final parcel keeps compressed words flowing at one per cycle.
        in_ready   = (r_state == IDLE) || (w_out_xfer && out_last);
        w_in_xfer  = in_valid && in_ready;

        case (r_state)
            IDLE: begin
                if (w_in_xfer) begin
                    w_state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                if (w_out_xfer) begin
                    if (!out_last) begin
                        w_state_nxt = SEND_HI;
                    end else if (w_in_xfer) begin
                        w_state_nxt = SEND_LO;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            SEND_HI: begin
                if (w_out_xfer) begin
                    w_state_nxt = w_in_xfer ? SEND_LO : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset drops any partially sent word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding register captures the word only on an accepted input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 32'h0000_0000;
        end else if (w_in_xfer) begin
            r_hold <= in_word;
        end
    end

    // Saturating count of words that left as a single zero-extended parcel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zext_cnt <= 8'h00;
        end else if (w_out_xfer && out_zext && (r_zext_cnt != 8'hFF)) begin
            r_zext_cnt <= r_zext_cnt + 8'd1;
        end
    end

    assign zext_cnt = r_zext_cnt;

endmodule

// File: tb/tb_halfword_narrower.sv
module tb_halfword_narrower;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_word;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_last,  out_zext;
    logic [15:0] out_half;
    logic [7:0]  zext_cnt;

    logic        in_ready0, out_valid0, out_last0, out_zext0;
    logic [15:0] out_half0;
    logic [7:0]  zext_cnt0;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    halfword_narrower #(.COMPRESS_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_half(out_half),
        .out_last(out_last), .out_zext(out_zext), .zext_cnt(zext_cnt)
    );

    halfword_narrower #(.COMPRESS_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0), .in_word(in_word),
        .out_valid(out_valid0), .out_ready(out_ready), .out_half(out_half0),
        .out_last(out_last0), .out_zext(out_zext0), .zext_cnt(zext_cnt0)
    );

    typedef struct {
        logic [31:0] word;
        logic        two;
        logic [15:0] lo;
        logic [15:0] hi;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_total);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{word: 32'h1234_ABCD, two: 1'b1, lo: 16'hABCD, hi: 16'h1234};
        vecs[1] = '{word: 32'h0000_BEEF, two: 1'b0, lo: 16'hBEEF, hi: 16'h0000};
        vecs[2] = '{word: 32'h0000_0000, two: 1'b0, lo: 16'h0000, hi: 16'h0000};
        vecs[3] = '{word: 32'hFFFF_0000, two: 1'b1, lo: 16'h0000, hi: 16'hFFFF};
        vecs[4] = '{word: 32'h0001_0000, two: 1'b1, lo: 16'h0000, hi: 16'h0001};

        // Reset state, checked before any clock edge.
        rst_n = 1'b0; in_valid = 1'b0; in_word = 32'h0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_half",  {16'h0, out_half},  32'h0);
        chk("rst_last_zext", {30'h0, out_last, out_zext}, 32'h0);
        chk("rst_zext_cnt",  {24'h0, zext_cnt},  32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        step();

        // Single words through the table, each starting from IDLE with out_ready=1.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_word = vecs[i].word; out_ready = 1'b1;
            #1;
            chk("vec_in_ready", {31'h0, in_ready}, 32'h1);
            step();
            in_valid = 1'b0; in_word = 32'hDEAD_DEAD;
            #1;
            chk("vec_lo_valid", {31'h0, out_valid}, 32'h1);
            chk("vec_lo_half",  {16'h0, out_half},  {16'h0, vecs[i].lo});
            chk("vec_lo_last",  {31'h0, out_last},  {31'h0, !vecs[i].two});
            chk("vec_lo_zext",  {31'h0, out_zext},  {31'h0, !vecs[i].two});
            if (vecs[i].two) begin
                step();
                chk("vec_hi_half", {16'h0, out_half}, {16'h0, vecs[i].hi});
                chk("vec_hi_last_zext", {30'h0, out_last, out_zext}, 32'h2);
            end else begin
                exp_cnt++;
            end
            step();
            chk("vec_idle_valid", {31'h0, out_valid}, 32'h0);
            chk("vec_zext_cnt", {24'h0, zext_cnt}, exp_cnt);
        end

        // Stall for 5 cycles in the upper-half parcel of CAFE_0001.
        in_valid = 1'b1; in_word = 32'hCAFE_0001; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("stall_lo_half", {16'h0, out_half}, 32'h0001);
        chk("stall_lo_last", {31'h0, out_last}, 32'h0);
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_hi_half",  {16'h0, out_half}, 32'hCAFE);
            chk("stall_hi_valid", {30'h0, out_valid, out_last}, 32'h3);
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        chk("stall_one_xfer", {31'h0, out_valid}, 32'h0);
        chk("stall_zext_cnt", {24'h0, zext_cnt}, exp_cnt);

        // Back-to-back compressed words 1..4, one parcel per cycle.
        in_valid = 1'b1; in_word = 32'h1; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready_first", {31'h0, in_ready}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("b2b_half", {16'h0, out_half}, k);
            chk("b2b_valid_last_zext", {29'h0, out_valid, out_last, out_zext}, 32'h7);
            if (k < 4) in_word = k + 1;
            else       in_valid = 1'b0;
            #1;
            chk("b2b_in_ready", {31'h0, in_ready}, 32'h1);
        end
        exp_cnt += 4;
        step();
        chk("b2b_done_valid", {31'h0, out_valid}, 32'h0);
        chk("b2b_zext_cnt", {24'h0, zext_cnt}, exp_cnt);

        // Reset pulse while holding the upper half of 5555_AAAA.
        in_valid = 1'b1; in_word = 32'h5555_AAAA; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        #1;
        chk("mid_rst_pre_half", {16'h0, out_half}, 32'h5555);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_half",  {16'h0, out_half},  32'h0);
        chk("mid_rst_cnt",   {24'h0, zext_cnt},  32'h0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mid_rst_no_parcel", {31'h0, out_valid}, 32'h0);
        end
        exp_cnt = 0;

        // Same upper-zero word into both compression settings.
        in_valid = 1'b1; in_word = 32'h0000_BEEF; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("c1_half",      {16'h0, out_half}, 32'hBEEF);
        chk("c1_last_zext", {30'h0, out_last, out_zext}, 32'h3);
        chk("c0_lo_half",   {16'h0, out_half0}, 32'hBEEF);
        chk("c0_lo_last_zext", {30'h0, out_last0, out_zext0}, 32'h0);
        step();
        exp_cnt++;
        chk("c1_zext_cnt",  {24'h0, zext_cnt}, exp_cnt);
        chk("c1_idle",      {31'h0, out_valid}, 32'h0);
        chk("c0_hi_valid",  {31'h0, out_valid0}, 32'h1);
        chk("c0_hi_half",   {16'h0, out_half0}, 32'h0000);
        chk("c0_hi_last_zext", {30'h0, out_last0, out_zext0}, 32'h2);
        step();
        chk("c0_idle",      {31'h0, out_valid0}, 32'h0);
        chk("c0_zext_cnt",  {24'h0, zext_cnt0}, 32'h0);

        // 300 compressed words drive the counter into saturation.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_word = {16'h0000, 16'(i)};
            step();
            if (i == 254) begin
                // 1 earlier word + 254 transferred here (words 0..253).
                chk("sat_cnt_255", {24'h0, zext_cnt}, 32'hFF);
            end
        end
        in_valid = 1'b0;
        step();
        chk("sat_cnt_final", {24'h0, zext_cnt}, 32'hFF);
        chk("sat_idle", {31'h0, out_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
